irq_controller: RTL and testbench

Interrupt controller on the I/O side of the backplane, directly upstream of Control's `INT_IN` input. It synchronises and edge-detects external interrupt sources, including a debounced active-low key line. Each event is latched as pending, masked, and presented to Control as a single level request. Software reads and clears it through the processor I/O strobes (`nIOR`/`nIOW`) on the shared 26-bit databus.

---
 rtl/lvdc_io_pkg.sv | 26 ++
 rtl/irq_debounce.sv | 52 +++++
 rtl/irq_controller.sv | 124 ++++++++++++
 tb/tb_irq_controller.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvdc_io_pkg.sv
// Shared constants for the LVDC I/O-side peripherals: register map, databus width
// and a small priority-encoder helper used by the interrupt controller.
package lvdc_io_pkg;

  localparam int DB_W          = 26;
  localparam int MAX_SRC       = 16;
  localparam int VEC_VALID_BIT = 4;

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_MASK   = 2'd1,
    REG_ACK    = 2'd2,
    REG_VECTOR = 2'd3
  } reg_off_e;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [3:0] lowest_set_idx(input logic [MAX_SRC-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_debounce.sv
// Key-line conditioner: 2-flop synchroniser, stability counter and accepted state,
// producing a one-cycle press pulse on each accepted high-to-low transition.
module irq_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The flip happens on the edge the count would reach DEBOUNCE_CYCLES, so the
  // press pulse is combinational and lands on that same edge downstream.
  always_comb begin
    sync1_d = key_n_i;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = '0;
    press_o = 1'b0;
    if (sync2_q != state_q) begin
      if (cnt_q == CNT_LAST) begin
        state_d = sync2_q;
        press_o = state_q & ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller feeding Control's INT_IN: edge-detected sources latch into
// pending, are masked, and are serviced through nIOR/nIOW on the shared databus.
module irq_controller
  import lvdc_io_pkg::*;
#(
  parameter int          N_SRC           = 8,
  parameter logic [7:0]  BASE_ADDR       = 8'h40,
  parameter int          DEBOUNCE_CYCLES = 1024
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             KEY_CLEARb,
  input  logic [N_SRC-1:1] SRC,
  input  logic [12:0]      I,
  input  logic             nIOR,
  input  logic             nIOW,
  inout  wire  [DB_W-1:0]  DB,
  output logic             INT_IN
);

  logic [N_SRC-1:1] src_s1_q, src_s1_d;
  logic [N_SRC-1:1] src_s2_q, src_s2_d;
  logic [N_SRC-1:1] src_prev_q, src_prev_d;
  logic             niow_q, niow_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic             int_q, int_d;

  logic             key_press;
  logic [N_SRC-1:0] set_vec;
  logic [N_SRC-1:0] enabled;
  logic [MAX_SRC-1:0] enabled_ext;
  logic [7:0]       addr_off;
  logic             addr_hit;
  reg_off_e         reg_sel;
  logic             wr_commit;
  logic             wr_mask;
  logic             wr_ack;
  logic [N_SRC-1:0] db_in;
  logic [DB_W-1:0]  rdata;
  logic             db_oe;
  logic             unused_bits;

  irq_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key (
    .clk     (CLK),
    .rst_n   (nRST),
    .key_n_i (KEY_CLEARb),
    .press_o (key_press)
  );

  // Subtracting the base keeps the decode correct for unaligned base addresses.
  assign addr_off  = I[7:0] - BASE_ADDR;
  assign addr_hit  = (addr_off[7:2] == 6'd0);
  assign reg_sel   = reg_off_e'(addr_off[1:0]);
  assign wr_commit = niow_q & ~nIOW;
  assign wr_mask   = wr_commit & addr_hit & (reg_sel == REG_MASK);
  assign wr_ack    = wr_commit & addr_hit & (reg_sel == REG_ACK);
  assign db_in     = DB[N_SRC-1:0];

  assign set_vec = {src_s2_q & ~src_prev_q, key_press};
  assign enabled = pending_q & mask_q;

  always_comb begin
    enabled_ext = '0;
    enabled_ext[N_SRC-1:0] = enabled;
  end

  // A new edge is OR-ed in after the ACK clear so that a colliding event survives.
  always_comb begin
    src_s1_d   = SRC;
    src_s2_d   = src_s1_q;
    src_prev_d = src_s2_q;
    niow_d     = nIOW;
    mask_d     = wr_mask ? db_in : mask_q;
    pending_d  = pending_q;
    if (wr_ack) begin
      pending_d = pending_d & ~db_in;
    end
    pending_d = pending_d | set_vec;
    int_d     = |enabled;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      src_s1_q   <= '0;
      src_s2_q   <= '0;
      src_prev_q <= '0;
      niow_q     <= 1'b0;
      pending_q  <= '0;
      mask_q     <= '0;
      int_q      <= 1'b0;
    end else begin
      src_s1_q   <= src_s1_d;
      src_s2_q   <= src_s2_d;
      src_prev_q <= src_prev_d;
      niow_q     <= niow_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      int_q      <= int_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_STATUS: rdata[N_SRC-1:0] = pending_q;
      REG_MASK:   rdata[N_SRC-1:0] = mask_q;
      REG_VECTOR: begin
        rdata[VEC_VALID_BIT] = |enabled;
        rdata[3:0]           = lowest_set_idx(enabled_ext);
      end
      default:    rdata = '0;
    endcase
  end

  assign db_oe  = ~nIOR & addr_hit;
  assign DB     = db_oe ? rdata : {DB_W{1'bz}};
  assign INT_IN = int_q;

  assign unused_bits = ^{I[12:8], DB[DB_W-1:N_SRC]};

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed tables, multi-cycle corner
// sequences and a randomized run against an event-level pending/mask model.
module tb_irq_controller;

  localparam int         N_SRC  = 8;
  localparam int         DEB    = 16;
  localparam logic [7:0] BASE   = 8'h40;
  localparam logic [7:0] A_STAT = BASE;
  localparam logic [7:0] A_MASK = BASE + 8'd1;
  localparam logic [7:0] A_ACK  = BASE + 8'd2;
  localparam logic [7:0] A_VEC  = BASE + 8'd3;
  localparam logic [25:0] HIZ   = '1;   // pulled-up bus value when nobody drives

  logic        CLK = 1'b0;
  logic        nRST;
  logic        KEY_CLEARb;
  logic [7:1]  SRC;
  logic [12:0] I;
  logic        nIOR;
  logic        nIOW;
  tri1 [25:0]  DB;
  logic        INT_IN;

  logic        db_oe;
  logic [25:0] db_out;
  assign DB = db_oe ? db_out : {26{1'bz}};

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_pending;
  logic [7:0] m_mask;

  typedef struct {
    logic       do_mask;
    logic [7:0] mask;
    logic [7:0] fire;
    logic [7:0] ack;
    logic [7:0] e_status;
    logic [7:0] e_vector;
    logic       e_int;
  } vec_t;

  vec_t tbl [8];

  irq_controller #(
    .N_SRC           (N_SRC),
    .BASE_ADDR       (BASE),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .KEY_CLEARb (KEY_CLEARb),
    .SRC        (SRC),
    .I          (I),
    .nIOR       (nIOR),
    .nIOW       (nIOW),
    .DB         (DB),
    .INT_IN     (INT_IN)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [7:0] addr, output logic [25:0] data);
    I    = {5'd0, addr};
    nIOR = 1'b0;
    #1;
    data = DB;
    nIOR = 1'b1;
    #1;
    $display("read  addr=0x%02h data=0x%07h", addr, data);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] addr, input logic [25:0] exp);
    logic [25:0] d;
    rd(addr, d);
    chk(name, 32'(d), 32'(exp));
  endtask

  task automatic wr_start(input logic [7:0] addr, input logic [25:0] data);
    I      = {5'd0, addr};
    db_out = data;
    db_oe  = 1'b1;
    nIOW   = 1'b0;
  endtask

  task automatic wr_end();
    nIOW  = 1'b1;
    db_oe = 1'b0;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [25:0] data);
    wr_start(addr, data);
    tick(1);
    wr_end();
    tick(1);
    $display("write addr=0x%02h data=0x%07h", addr, data);
  endtask

  function automatic logic [7:0] model_vector(input logic [7:0] p, input logic [7:0] m);
    logic [7:0] e;
    e = p & m;
    for (int n = 0; n < 8; n++) begin
      if (e[n]) return 8'(16 + n);
    end
    return 8'h00;
  endfunction

  task automatic check_model(input string tag);
    rd_chk({tag, "_status"}, A_STAT, 26'(m_pending));
    rd_chk({tag, "_vector"}, A_VEC, 26'(model_vector(m_pending, m_mask)));
    rd_chk({tag, "_mask"}, A_MASK, 26'(m_mask));
    chk({tag, "_int"}, 32'(INT_IN), 32'(|(m_pending & m_mask)));
  endtask

  initial begin
    logic [7:0] v;
    int         op;

    tbl[0] = '{1'b1, 8'h0A, 8'h2A, 8'h00, 8'h2A, 8'h11, 1'b1};
    tbl[1] = '{1'b0, 8'h00, 8'h00, 8'h02, 8'h28, 8'h13, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 8'h00, 8'h08, 8'h20, 8'h00, 1'b0};
    tbl[3] = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'h20, 8'h15, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 8'h80, 8'h00, 8'hA0, 8'h15, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 8'h00, 8'h20, 8'h80, 8'h17, 1'b1};
    tbl[6] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0};

    // Reset with sources and key toggling.
    nRST = 1'b0; KEY_CLEARb = 1'b1; SRC = '0; I = '0;
    nIOR = 1'b1; nIOW = 1'b1; db_oe = 1'b0; db_out = '0;
    m_pending = '0; m_mask = '0;
    for (int c = 0; c < 12; c++) begin
      SRC = 7'($urandom);
      KEY_CLEARb = c[0];
      tick(1);
    end
    chk("rst_int", 32'(INT_IN), 32'(0));
    chk("rst_db_hiz", 32'(DB), 32'(HIZ));
    SRC = '0; KEY_CLEARb = 1'b1;
    nRST = 1'b1;
    tick(2);
    rd_chk("rst_status", A_STAT, 26'h0);
    rd_chk("rst_mask", A_MASK, 26'h0);
    rd_chk("rst_vector", A_VEC, 26'h0);

    // Single source: latency of pending and INT_IN, then ACK latency.
    wr(A_MASK, 26'h04); m_mask = 8'h04;
    SRC[2] = 1'b1;              // sampled at the next edge k
    tick(1); SRC = '0;          // after k
    tick(1);                    // after k+1
    rd_chk("src_lat_early", A_STAT, 26'h00);
    tick(1);                    // after k+2
    rd_chk("src_lat_status", A_STAT, 26'h04);
    rd_chk("src_lat_vector", A_VEC, 26'h12);
    chk("src_lat_int_early", 32'(INT_IN), 32'(0));
    tick(1);                    // after k+3
    chk("src_lat_int", 32'(INT_IN), 32'(1));
    wr_start(A_ACK, 26'h04);
    tick(1);                    // commit edge c
    wr_end();
    rd_chk("ack_status", A_STAT, 26'h00);
    chk("ack_int_hold", 32'(INT_IN), 32'(1));
    tick(1);                    // after c+1
    chk("ack_int_drop", 32'(INT_IN), 32'(0));

    // Priority and masking table.
    for (int r = 0; r < 8; r++) begin
      if (tbl[r].do_mask) wr(A_MASK, 26'(tbl[r].mask));
      if (tbl[r].fire != 8'h00) begin
        SRC = tbl[r].fire[7:1];
        tick(1);
        SRC = '0;
        tick(4);
      end
      if (tbl[r].ack != 8'h00) wr(A_ACK, 26'(tbl[r].ack));
      rd_chk($sformatf("tbl%0d_status", r), A_STAT, 26'(tbl[r].e_status));
      rd_chk($sformatf("tbl%0d_vector", r), A_VEC, 26'(tbl[r].e_vector));
      chk($sformatf("tbl%0d_int", r), 32'(INT_IN), 32'(tbl[r].e_int));
    end
    m_pending = '0; m_mask = '0;

    // Collision: ACK of bits 1 and 2 commits on the edge a new source-1 event lands.
    SRC = 7'b0000011; tick(1); SRC = '0; tick(4);
    rd_chk("coll_pre", A_STAT, 26'h06);
    SRC[1] = 1'b1;
    tick(1); SRC = '0;
    tick(1);
    wr_start(A_ACK, 26'h06);
    tick(1);
    wr_end();
    tick(1);
    rd_chk("coll_status", A_STAT, 26'h02);
    m_pending = 8'h02;

    // Long strobe with data changing mid-strobe.
    wr_start(A_MASK, 26'h5A);
    tick(1);
    db_out = 26'hFF;
    tick(4);
    wr_end();
    tick(1);
    rd_chk("long_strobe_mask", A_MASK, 26'h5A);
    m_mask = 8'h5A;

    // Undecoded addresses.
    wr(BASE + 8'd4, 26'hFF);
    wr(BASE + 8'd5, 26'hFF);
    wr(BASE + 8'd6, 26'hFF);
    wr(BASE - 8'd1, 26'hFF);
    rd_chk("undec_mask", A_MASK, 26'h5A);
    rd_chk("undec_status", A_STAT, 26'h02);
    rd_chk("undec_rd_plus4", BASE + 8'd4, HIZ);
    rd_chk("undec_rd_minus1", BASE - 8'd1, HIZ);
    rd_chk("ack_reads_zero", A_ACK, 26'h0);
    I = {5'd0, A_STAT};
    #1;
    chk("idle_db_hiz", 32'(DB), 32'(HIZ));
    wr(A_ACK, 26'h02); wr(A_MASK, 26'h00);
    m_pending = '0; m_mask = '0;

    // Key: bounces shorter than the debounce window are ignored.
    for (int b = 0; b < 4; b++) begin
      KEY_CLEARb = 1'b0; tick(5);
      KEY_CLEARb = 1'b1; tick(5);
    end
    tick(20);
    rd_chk("key_bounce", A_STAT, 26'h0);
    // Stable press: pending[0] exactly 17 edges after the first low sample.
    KEY_CLEARb = 1'b0;
    tick(17);
    rd_chk("key_lat_early", A_STAT, 26'h0);
    tick(1);
    rd_chk("key_lat", A_STAT, 26'h1);
    tick(82);
    rd_chk("key_held", A_STAT, 26'h1);
    wr(A_ACK, 26'h01);
    tick(20);
    rd_chk("key_held_once", A_STAT, 26'h0);
    KEY_CLEARb = 1'b1;
    tick(40);
    rd_chk("key_release", A_STAT, 26'h0);
    KEY_CLEARb = 1'b0;
    tick(40);
    rd_chk("key_second", A_STAT, 26'h1);
    wr(A_ACK, 26'h01);
    KEY_CLEARb = 1'b1;
    tick(40);

    // Reset in the middle of a debounce count restarts it.
    KEY_CLEARb = 1'b0;
    tick(10);
    nRST = 1'b0; tick(1); nRST = 1'b1;
    tick(10);
    rd_chk("key_rst_early", A_STAT, 26'h0);
    tick(10);
    rd_chk("key_rst_late", A_STAT, 26'h1);
    wr(A_ACK, 26'h01);
    KEY_CLEARb = 1'b1;
    tick(40);

    // Reset during a strobe; the strobe still low at release must not commit.
    wr_start(A_MASK, 26'h33);
    tick(1);
    nRST = 1'b0; tick(1); nRST = 1'b1;
    tick(3);
    wr_end();
    tick(1);
    rd_chk("rst_strobe_mask", A_MASK, 26'h0);
    chk("rst_strobe_int", 32'(INT_IN), 32'(0));
    m_pending = '0; m_mask = '0;

    // Randomized operations against the pending/mask model.
    for (int it = 0; it < 150; it++) begin
      op = $urandom_range(0, 3);
      v  = 8'($urandom);
      case (op)
        0: begin
          v   = v & 8'hFE;
          SRC = v[7:1];
          tick(1);
          SRC = '0;
          tick(4);
          m_pending = m_pending | v;
        end
        1: begin
          wr(A_MASK, 26'(v));
          m_mask = v;
        end
        2: begin
          wr(A_ACK, 26'(v));
          m_pending = m_pending & ~v;
        end
        default: tick(2);
      endcase
      check_model($sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
